spi_regbank_rw: RTL and testbench



---
 rtl/spi_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 27 ++
 rtl/spi_regbank_rw.sv | 208 ++++++++++++++++++++
 tb/tb_spi_regbank_rw.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI register-bank front end.
//   SPI_RW_WRITE : value of the leading R/W frame bit that selects a write
//   spi_state_t  : frame-decoder FSM states
//   frame_w()    : total frame length in bits (R/W + address + data)
package spi_pkg;

   localparam logic SPI_RW_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WDATA,
      RDATA,
      DONE
   } spi_state_t;

   function automatic int unsigned frame_w(input int unsigned addr_w, input int unsigned data_w);
      return 1 + addr_w + data_w;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous input.
//   clk : destination clock
//   rst : synchronous active-high reset, loads RST_VAL into both flops
//   d   : asynchronous input
//   q   : synchronised output
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/spi_regbank_rw.sv
// SPI mode-0 peripheral exposing NUM_REGS read/write configuration registers.
// Frame, MSB first: R/W (1 = write), ADDR_W address bits, DATA_W data bits.
//   clk       : system clock
//   rst       : synchronous active-high reset
//   SCLK      : SPI clock (asynchronous)
//   nCS       : SPI chip select, active low (asynchronous)
//   COPI      : controller-out data (asynchronous)
//   CIPO      : peripheral-out data, 0 when not driving read data
//   cipo_oe   : high while in the read data phase
//   regs      : flat register contents, register i at [i*DATA_W +: DATA_W]
//   wr_pulse  : one-clk strobe per register on a committed write
//   frame_err : one-clk pulse when a frame is aborted before completion
module spi_regbank_rw
   import spi_pkg::*;
#(
   parameter int unsigned NUM_REGS = 5,
   parameter int unsigned ADDR_W = 7,
   parameter int unsigned DATA_W = 8,
   parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         SCLK,
   input  logic                         nCS,
   input  logic                         COPI,
   output logic                         CIPO,
   output logic                         cipo_oe,
   output logic [NUM_REGS*DATA_W-1:0]   regs,
   output logic [NUM_REGS-1:0]          wr_pulse,
   output logic                         frame_err
);

   localparam int unsigned FRAME_W = frame_w(ADDR_W, DATA_W);
   localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);

   logic sclk_s, ncs_s, copi_s;
   logic sclk_d, ncs_d;
   logic sclk_rise, sclk_fall, ncs_fall;
   logic [1:0] settle;
   logic settled;

   spi_state_t          state;
   logic [CNT_W-1:0]    cnt;
   logic [ADDR_W-1:0]   cmd_sr;
   logic [ADDR_W-1:0]   addr;
   logic                addr_valid;
   logic [DATA_W-1:0]   wr_sr;
   logic [DATA_W-1:0]   rd_shift;
   logic                fall_pend;
   logic                commit_req;
   logic [DATA_W-1:0]   commit_data;

   logic [ADDR_W:0]     cmd_full;
   logic [ADDR_W-1:0]   cmd_addr;
   logic                cmd_rw;
   logic                cmd_in_range;
   logic [DATA_W-1:0]   rd_val;
   logic [DATA_W-1:0]   wr_next;

   sync_2ff #(.RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(SCLK), .q(sclk_s));
   sync_2ff #(.RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst(rst), .d(nCS),  .q(ncs_s));
   sync_2ff #(.RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst(rst), .d(COPI), .q(copi_s));

   // The nCS synchroniser resets to 1, so if the pin is held low across reset
   // a false fall appears two cycles after release. settle masks that window
   // so only a fresh fall after reset starts a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_d <= 1'b0;
         ncs_d  <= 1'b1;
         settle <= '0;
      end else begin
         sclk_d <= sclk_s;
         ncs_d  <= ncs_s;
         if (settle != 2'd3) settle <= settle + 2'd1;
      end
   end

   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ncs_fall  = ~ncs_s & ncs_d;
   assign settled   = (settle == 2'd3);

   // Command word including the bit arriving on this rise.
   assign cmd_full = {cmd_sr, copi_s};
   assign cmd_addr = cmd_full[ADDR_W-1:0];
   assign cmd_rw   = cmd_full[ADDR_W];
   assign wr_next  = {wr_sr[DATA_W-2:0], copi_s};

   always_comb begin
      rd_val       = '0;
      cmd_in_range = 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (cmd_addr == ADDR_W'(i)) begin
            rd_val       = regs[i*DATA_W +: DATA_W];
            cmd_in_range = 1'b1;
         end
      end
   end

   // Frame decoder. A completed write is handed to the register bank through
   // commit_req, which adds the one-cycle write latency after detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         cmd_sr      <= '0;
         addr        <= '0;
         addr_valid  <= 1'b0;
         wr_sr       <= '0;
         rd_shift    <= '0;
         fall_pend   <= 1'b0;
         commit_req  <= 1'b0;
         commit_data <= '0;
         frame_err   <= 1'b0;
         CIPO        <= 1'b0;
         cipo_oe     <= 1'b0;
      end else begin
         frame_err  <= 1'b0;
         commit_req <= 1'b0;
         fall_pend  <= 1'b0;
         if (ncs_s) begin
            // Deselect takes priority over any coincident SCLK edge.
            if (state inside {CMD, WDATA, RDATA}) frame_err <= 1'b1;
            state   <= IDLE;
            CIPO    <= 1'b0;
            cipo_oe <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  if (ncs_fall && settled) begin
                     state <= CMD;
                     cnt   <= '0;
                  end
               end
               CMD: begin
                  if (sclk_rise) begin
                     cmd_sr <= cmd_full[ADDR_W-1:0];
                     cnt    <= cnt + 1'b1;
                     if (cnt == CNT_W'(ADDR_W)) begin
                        cnt        <= '0;
                        addr       <= cmd_addr;
                        addr_valid <= cmd_in_range;
                        if (cmd_rw == SPI_RW_WRITE) begin
                           state <= WDATA;
                        end else begin
                           rd_shift <= rd_val;
                           CIPO     <= rd_val[DATA_W-1];
                           cipo_oe  <= 1'b1;
                           state    <= RDATA;
                        end
                     end
                  end
               end
               WDATA: begin
                  if (sclk_rise) begin
                     wr_sr <= wr_next;
                     cnt   <= cnt + 1'b1;
                     if (cnt == CNT_W'(DATA_W - 1)) begin
                        commit_req  <= addr_valid;
                        commit_data <= wr_next;
                        state       <= DONE;
                     end
                  end
               end
               RDATA: begin
                  // Each detected fall presents the next bit one cycle later;
                  // the fall right after entry re-presents the MSB.
                  if (sclk_fall) fall_pend <= 1'b1;
                  if (fall_pend) begin
                     CIPO     <= rd_shift[DATA_W-1];
                     rd_shift <= rd_shift << 1;
                  end
                  if (sclk_rise) begin
                     cnt <= cnt + 1'b1;
                     if (cnt == CNT_W'(DATA_W - 1)) begin
                        state   <= DONE;
                        CIPO    <= 1'b0;
                        cipo_oe <= 1'b0;
                     end
                  end
               end
               DONE: begin
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         regs     <= RESET_VAL;
         wr_pulse <= '0;
      end else begin
         wr_pulse <= '0;
         if (commit_req) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
               if (addr == ADDR_W'(i)) begin
                  regs[i*DATA_W +: DATA_W] <= commit_data;
                  wr_pulse[i]              <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_regbank_rw.sv
// Self-checking bench for spi_regbank_rw with default geometry and a
// non-zero reset image; expectations come from a register-array model.
module tb_spi_regbank_rw;

   localparam logic [39:0] RV = 40'h9A_78_56_34_12;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        SCLK = 1'b0;
   logic        nCS = 1'b1;
   logic        COPI = 1'b0;
   logic        CIPO;
   logic        cipo_oe;
   logic [39:0] regs;
   logic [4:0]  wr_pulse;
   logic        frame_err;

   int n_cmp = 0;
   int n_fail = 0;

   logic [7:0] model [5];
   int pulse_cnt [5];
   int exp_pulse [5];
   int ferr_cnt = 0;
   int exp_ferr = 0;

   spi_regbank_rw #(
      .NUM_REGS(5),
      .ADDR_W(7),
      .DATA_W(8),
      .RESET_VAL(RV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .SCLK(SCLK),
      .nCS(nCS),
      .COPI(COPI),
      .CIPO(CIPO),
      .cipo_oe(cipo_oe),
      .regs(regs),
      .wr_pulse(wr_pulse),
      .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // Event counters plus the CIPO-quiet-when-not-enabled invariant.
   always @(negedge clk) begin
      for (int i = 0; i < 5; i++) if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;
      if (frame_err === 1'b1) ferr_cnt++;
      n_cmp++;
      if (cipo_oe !== 1'b1 && CIPO !== 1'b0) begin
         n_fail++;
         $display("FAIL cipo_idle: CIPO=%b while cipo_oe=%b, required 0", CIPO, cipo_oe);
      end
   end

   initial begin
      #900000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $fatal(1, "timeout");
   end

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic logic [39:0] exp_flat();
      logic [39:0] f;
      for (int i = 0; i < 5; i++) f[i*8 +: 8] = model[i];
      return f;
   endfunction

   function automatic void model_reset();
      logic [39:0] r;
      r = RV;
      for (int i = 0; i < 5; i++) model[i] = r[i*8 +: 8];
   endfunction

   function automatic void model_write(input int a, input logic [7:0] d);
      if (a < 5) begin
         model[a] = d;
         exp_pulse[a]++;
      end
   endfunction

   task automatic send_bit(input logic b, output logic rxb, output logic oeb);
      COPI = b;
      wait_clk(6);
      rxb  = CIPO;
      oeb  = cipo_oe;
      SCLK = 1'b1;
      wait_clk(6);
      SCLK = 1'b0;
   endtask

   task automatic xfer(input logic [31:0] bits, input int n, input int stop_at, input int gap,
                       output logic [31:0] rx, output logic [31:0] oe);
      logic rb, ob;
      rx = '0;
      oe = '0;
      nCS = 1'b0;
      wait_clk(6);
      for (int i = 0; i < n; i++) begin
         if (i == stop_at) break;
         send_bit(bits[n-1-i], rb, ob);
         rx[n-1-i] = rb;
         oe[n-1-i] = ob;
      end
      wait_clk(6);
      nCS = 1'b1;
      wait_clk(gap);
   endtask

   task automatic do_write(input int a, input logic [7:0] d, input int gap);
      logic [31:0] rx, oe;
      logic [6:0] a7;
      a7 = 7'(a);
      xfer({16'h0, 1'b1, a7, d}, 16, -1, gap, rx, oe);
      model_write(a, d);
   endtask

   task automatic do_read(input int a, output logic [7:0] d, output logic [15:0] oe16);
      logic [31:0] rx, oe;
      logic [6:0] a7;
      a7 = 7'(a);
      xfer({16'h0, 1'b0, a7, 8'h00}, 16, -1, 10, rx, oe);
      d    = rx[7:0];
      oe16 = oe[15:0];
   endtask

   task automatic test_reset();
      rst = 1'b1;
      wait_clk(5);
      n_cmp++; if (regs !== RV) begin n_fail++; $display("FAIL reset_regs: got %h want %h", regs, RV); end
      n_cmp++; if (wr_pulse !== 5'b0) begin n_fail++; $display("FAIL reset_wr_pulse: got %b want 00000", wr_pulse); end
      n_cmp++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
      n_cmp++; if (cipo_oe !== 1'b0 || CIPO !== 1'b0) begin n_fail++; $display("FAIL reset_cipo: got oe=%b cipo=%b want 0/0", cipo_oe, CIPO); end
      rst = 1'b0;
      wait_clk(5);
   endtask

   // Write 0xA5 to register 4 and check the commit lands exactly 4 clk after the final SCLK rise.
   task automatic test_write_latency();
      logic [15:0] bits;
      logic rb, ob;
      logic [7:0] old4;
      bits = {1'b1, 7'd4, 8'hA5};
      old4 = model[4];
      nCS = 1'b0;
      wait_clk(6);
      for (int i = 0; i < 15; i++) send_bit(bits[15-i], rb, ob);
      COPI = bits[0];
      wait_clk(6);
      SCLK = 1'b1;
      wait_clk(3);
      n_cmp++; if (regs[39:32] !== old4 || wr_pulse !== 5'b0) begin
         n_fail++; $display("FAIL wr_early: got reg4=%h pulse=%b want %h/00000", regs[39:32], wr_pulse, old4); end
      wait_clk(1);
      n_cmp++; if (regs[39:32] !== 8'hA5 || wr_pulse !== 5'b10000) begin
         n_fail++; $display("FAIL wr_commit: got reg4=%h pulse=%b want a5/10000", regs[39:32], wr_pulse); end
      wait_clk(1);
      n_cmp++; if (wr_pulse !== 5'b0) begin n_fail++; $display("FAIL wr_pulse_len: got %b want 00000", wr_pulse); end
      wait_clk(1);
      SCLK = 1'b0;
      wait_clk(6);
      nCS = 1'b1;
      wait_clk(10);
      model_write(4, 8'hA5);
      n_cmp++; if (regs !== exp_flat()) begin n_fail++; $display("FAIL wr_a5_regs: got %h want %h", regs, exp_flat()); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (pulse_cnt[i] !== exp_pulse[i]) begin n_fail++; $display("FAIL wr_a5_pulses[%0d]: got %0d want %0d", i, pulse_cnt[i], exp_pulse[i]); end
      end
   endtask

   task automatic test_write_read();
      logic [7:0] d;
      logic [15:0] oe;
      do_write(2, 8'h3C, 10);
      do_read(2, d, oe);
      n_cmp++; if (d !== 8'h3C) begin n_fail++; $display("FAIL rd_3c: got %h want 3c", d); end
      n_cmp++; if (oe !== 16'h00FF) begin n_fail++; $display("FAIL rd_oe_window: got %h want 00ff", oe); end
      n_cmp++; if (cipo_oe !== 1'b0) begin n_fail++; $display("FAIL rd_oe_after: got %b want 0", cipo_oe); end
      n_cmp++; if (regs !== exp_flat()) begin n_fail++; $display("FAIL rd_regs: got %h want %h", regs, exp_flat()); end
   endtask

   task automatic test_out_of_range();
      logic [7:0] d;
      logic [15:0] oe;
      do_write(5, 8'h77, 10);
      do_write(127, 8'h66, 10);
      n_cmp++; if (regs !== exp_flat()) begin n_fail++; $display("FAIL oor_regs: got %h want %h", regs, exp_flat()); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (pulse_cnt[i] !== exp_pulse[i]) begin n_fail++; $display("FAIL oor_pulses[%0d]: got %0d want %0d", i, pulse_cnt[i], exp_pulse[i]); end
      end
      do_read(127, d, oe);
      n_cmp++; if (d !== 8'h00) begin n_fail++; $display("FAIL oor_read: got %h want 00", d); end
   endtask

   task automatic test_abort();
      logic [31:0] rx, oe;
      xfer({16'h0, 1'b1, 7'd0, 8'hFF}, 16, 10, 10, rx, oe);
      exp_ferr++;
      n_cmp++; if (regs !== exp_flat()) begin n_fail++; $display("FAIL abort_regs: got %h want %h", regs, exp_flat()); end
      n_cmp++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL abort_frame_err: got %0d want %0d", ferr_cnt, exp_ferr); end
      n_cmp++; if (pulse_cnt[0] !== exp_pulse[0]) begin n_fail++; $display("FAIL abort_pulse: got %0d want %0d", pulse_cnt[0], exp_pulse[0]); end
   endtask

   task automatic test_overlength();
      logic [31:0] rx, oe;
      xfer({12'h0, 1'b1, 7'd1, 8'h11, 4'hB}, 20, -1, 10, rx, oe);
      model_write(1, 8'h11);
      n_cmp++; if (regs !== exp_flat()) begin n_fail++; $display("FAIL ovl_regs: got %h want %h", regs, exp_flat()); end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (pulse_cnt[i] !== exp_pulse[i]) begin n_fail++; $display("FAIL ovl_pulses[%0d]: got %0d want %0d", i, pulse_cnt[i], exp_pulse[i]); end
      end
      n_cmp++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL ovl_frame_err: got %0d want %0d", ferr_cnt, exp_ferr); end
   endtask

   // Reset lands mid-frame with nCS still low; nCS is only raised after release.
   task automatic test_reset_midframe();
      logic [15:0] bits;
      logic rb, ob;
      bits = {1'b1, 7'd3, 8'hE7};
      nCS = 1'b0;
      wait_clk(6);
      for (int i = 0; i < 12; i++) send_bit(bits[15-i], rb, ob);
      rst = 1'b1;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(8);
      nCS = 1'b1;
      wait_clk(10);
      model_reset();
      n_cmp++; if (regs !== RV) begin n_fail++; $display("FAIL rstmid_regs: got %h want %h", regs, RV); end
      n_cmp++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL rstmid_frame_err: got %0d want %0d", ferr_cnt, exp_ferr); end
      do_write(3, 8'hE7, 10);
      n_cmp++; if (regs !== exp_flat()) begin n_fail++; $display("FAIL rstmid_next: got %h want %h", regs, exp_flat()); end
      n_cmp++; if (pulse_cnt[3] !== exp_pulse[3]) begin n_fail++; $display("FAIL rstmid_pulse: got %0d want %0d", pulse_cnt[3], exp_pulse[3]); end
   endtask

   task automatic test_back_to_back();
      do_write(0, 8'h5A, 4);
      do_write(1, 8'hC3, 4);
      do_write(0, 8'h96, 10);
      n_cmp++; if (regs !== exp_flat()) begin n_fail++; $display("FAIL b2b_regs: got %h want %h", regs, exp_flat()); end
      n_cmp++; if (pulse_cnt[0] !== exp_pulse[0] || pulse_cnt[1] !== exp_pulse[1]) begin
         n_fail++; $display("FAIL b2b_pulses: got %0d/%0d want %0d/%0d", pulse_cnt[0], pulse_cnt[1], exp_pulse[0], exp_pulse[1]); end
   endtask

   task automatic test_random();
      logic [7:0] d, got, want;
      logic [15:0] oe;
      int a;
      for (int k = 0; k < 24; k++) begin
         a = ($urandom % 4 == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 4));
         d = 8'($urandom);
         if ($urandom % 2 == 1) begin
            do_write(a, d, 10);
            n_cmp++; if (regs !== exp_flat()) begin n_fail++; $display("FAIL rnd_wr a=%0d: got %h want %h", a, regs, exp_flat()); end
         end else begin
            want = (a < 5) ? model[a] : 8'h00;
            do_read(a, got, oe);
            n_cmp++; if (got !== want) begin n_fail++; $display("FAIL rnd_rd a=%0d: got %h want %h", a, got, want); end
            n_cmp++; if (oe !== 16'h00FF) begin n_fail++; $display("FAIL rnd_oe a=%0d: got %h want 00ff", a, oe); end
         end
      end
      for (int i = 0; i < 5; i++) begin
         n_cmp++; if (pulse_cnt[i] !== exp_pulse[i]) begin n_fail++; $display("FAIL rnd_pulses[%0d]: got %0d want %0d", i, pulse_cnt[i], exp_pulse[i]); end
      end
      n_cmp++; if (ferr_cnt !== exp_ferr) begin n_fail++; $display("FAIL rnd_frame_err: got %0d want %0d", ferr_cnt, exp_ferr); end
   endtask

   initial begin
      for (int i = 0; i < 5; i++) begin
         pulse_cnt[i] = 0;
         exp_pulse[i] = 0;
      end
      model_reset();
      test_reset();
      test_write_latency();
      test_write_read();
      test_out_of_range();
      test_abort();
      test_overlength();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
